// File: rtl/fma_pkg.sv
// Shared definitions for the single-precision FMA pipeline.
// Contents:
//   EXP_W, SIG_W, FLAG_W   default field widths of a binary32 result
//   FLG_NV..FLG_NX         exception flag bit positions within the flags field
//   fma_result_t           packed result word {sign, exp, sig, flags}
//   slice_state_t          occupancy state of a pipeline register slice
//   occ_of()               entry count held in a given slice state
package fma_pkg;

  localparam int EXP_W  = 8;
  localparam int SIG_W  = 23;
  localparam int FLAG_W = 5;

  localparam int FLG_NV = 4;  // invalid operation
  localparam int FLG_DZ = 3;  // divide by zero
  localparam int FLG_OF = 2;  // overflow
  localparam int FLG_UF = 1;  // underflow
  localparam int FLG_NX = 0;  // inexact

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [SIG_W-1:0]  sig;
    logic [FLAG_W-1:0] flags;
  } fma_result_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

  function automatic logic [1:0] occ_of(input slice_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fma_skid_reg.sv
// Generic payload register with a valid/ready handshake.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   flush             synchronous discard of everything held
//   in_valid/in_ready/in_data     upstream side
//   out_valid/out_ready/out_data  downstream side
//   state_dbg         current occupancy state (EMPTY/ONE/FULL)
// SKID=1: two entries (main + skid), in_ready decoded from the state register
//         only, so downstream ready never reaches upstream combinationally.
// SKID=0: one entry, in_ready = !out_valid | out_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on the same side; valid must not depend on ready, and a source
// holding valid without ready keeps its data unchanged until the transfer.
module fma_skid_reg
  import fma_pkg::*;
#(
  parameter int W    = 32,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output slice_state_t state_dbg
);

  if (SKID) begin : g_skid

    slice_state_t state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign state_dbg = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // main is stalled, so the newcomer parks behind it
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      // Flush wins over any transfer on either side; data registers keep
      // their stale contents since nothing is valid afterwards.
      if (flush) begin
        state_d = EMPTY;
        main_d  = main_q;
        skid_d  = skid_q;
      end
    end

  end else begin : g_single

    logic         valid_q, valid_d;
    logic [W-1:0] main_q, main_d;
    logic         in_fire, out_fire;

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign state_dbg = valid_q ? ONE : EMPTY;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (in_fire) begin
        main_d  = in_data;
        valid_d = 1'b1;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

  end

endmodule

// File: rtl/fma_pipe_slice.sv
// Pipeline register slice for the single-precision FMA result.
// Packs {sign, exp, sig, flags} into one payload word, registers it through
// fma_skid_reg, and unpacks it on the far side. Fields pass bit-exact.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   flush                          synchronous discard of held entries
//   in_valid, in_ready             upstream handshake
//   in_sign/in_exp/in_sig/in_flags result fields from the previous stage
//   out_valid, out_ready           downstream handshake
//   out_sign/out_exp/out_sig/out_flags registered result fields
//   occupancy                      entries held (0..2, at most 1 when SKID=0)
module fma_pipe_slice #(
  parameter int EXP_W  = 8,
  parameter int SIG_W  = 23,
  parameter int FLAG_W = 5,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [SIG_W-1:0]  in_sig,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [SIG_W-1:0]  out_sig,
  output logic [FLAG_W-1:0] out_flags,
  output logic [1:0]        occupancy
);

  import fma_pkg::slice_state_t;
  import fma_pkg::occ_of;

  // Same field order as fma_pkg::fma_result_t, sized by this slice's widths.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [SIG_W-1:0]  sig;
    logic [FLAG_W-1:0] flags;
  } slot_t;

  localparam int W = $bits(slot_t);

  slot_t        in_slot;
  slot_t        out_slot;
  slice_state_t state_dbg;

  assign in_slot = '{sign: in_sign, exp: in_exp, sig: in_sig, flags: in_flags};

  fma_skid_reg #(
    .W    (W),
    .SKID (SKID)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_slot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_slot),
    .state_dbg (state_dbg)
  );

  assign out_sign  = out_slot.sign;
  assign out_exp   = out_slot.exp;
  assign out_sig   = out_slot.sig;
  assign out_flags = out_slot.flags;
  assign occupancy = occ_of(state_dbg);

endmodule

// File: tb/tb_fma_pipe_slice.sv
// Directed bench for fma_pipe_slice: one SKID=1 instance (a_*) and one
// SKID=0 instance (b_*) sharing clock and reset.
module tb_fma_pipe_slice;

  localparam int W = 37;  // {flags, sign, exp, sig}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- SKID=1 instance ----------------
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_word;
  logic [4:0]  a_in_flags, a_out_flags;
  logic        a_in_sign, a_out_sign;
  logic [7:0]  a_in_exp, a_out_exp;
  logic [22:0] a_in_sig, a_out_sig;
  logic [1:0]  a_occ;
  logic [31:0] a_out_word;

  assign {a_in_sign, a_in_exp, a_in_sig} = a_in_word;
  assign a_out_word = {a_out_sign, a_out_exp, a_out_sig};

  fma_pipe_slice #(.EXP_W(8), .SIG_W(23), .FLAG_W(5), .SKID(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sign(a_in_sign), .in_exp(a_in_exp), .in_sig(a_in_sig), .in_flags(a_in_flags),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sign(a_out_sign), .out_exp(a_out_exp), .out_sig(a_out_sig), .out_flags(a_out_flags),
    .occupancy(a_occ)
  );

  // ---------------- SKID=0 instance ----------------
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_word;
  logic [4:0]  b_in_flags, b_out_flags;
  logic        b_in_sign, b_out_sign;
  logic [7:0]  b_in_exp, b_out_exp;
  logic [22:0] b_in_sig, b_out_sig;
  logic [1:0]  b_occ;
  logic [31:0] b_out_word;

  assign {b_in_sign, b_in_exp, b_in_sig} = b_in_word;
  assign b_out_word = {b_out_sign, b_out_exp, b_out_sig};

  fma_pipe_slice #(.EXP_W(8), .SIG_W(23), .FLAG_W(5), .SKID(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sign(b_in_sign), .in_exp(b_in_exp), .in_sig(b_in_sig), .in_flags(b_in_flags),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sign(b_out_sign), .out_exp(b_out_exp), .out_sig(b_out_sig), .out_flags(b_out_flags),
    .occupancy(b_occ)
  );

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] w, input logic [4:0] f);
    a_in_valid = v;
    a_in_word  = w;
    a_in_flags = f;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] w, input logic [4:0] f);
    b_in_valid = v;
    b_in_word  = w;
    b_in_flags = f;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic        mv, exp_rdy, in_f, out_f;
    logic [31:0] cur;
    logic [W-1:0] front;
    int          sent, got;

    rst = 1'b0;
    a_flush = 1'b0; a_out_ready = 1'b0; drive_a(1'b0, 32'h0, 5'h0);
    b_flush = 1'b0; b_out_ready = 1'b0; drive_b(1'b0, 32'h0, 5'h0);

    // reset state
    #12;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_occ",   a_occ, 0);
    chk("rst_a_word",  a_out_word, 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_occ",   b_occ, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_a_ready", a_in_ready, 1);
    chk("post_rst_b_ready", b_in_ready, 1);

    // SKID=1 back-to-back stream with out_ready high
    a_out_ready = 1'b1;
    drive_a(1'b1, 32'h3F80_0000, 5'h0);
    tick();
    chk("s1_stream_w0",   a_out_word, 32'h3F80_0000);
    chk("s1_stream_v0",   a_out_valid, 1);
    chk("s1_stream_occ0", a_occ, 1);
    chk("s1_stream_rdy0", a_in_ready, 1);
    drive_a(1'b1, 32'hC020_0000, 5'h0);
    tick();
    chk("s1_stream_w1",   a_out_word, 32'hC020_0000);
    chk("s1_stream_occ1", a_occ, 1);
    chk("s1_stream_rdy1", a_in_ready, 1);
    drive_a(1'b0, 32'h0, 5'h0);
    tick();
    chk("s1_drain_valid", a_out_valid, 0);
    chk("s1_drain_occ",   a_occ, 0);
    chk("s1_idle_hold",   a_out_word, 32'hC020_0000);

    // SKID=1 backpressure fills the skid entry
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h3F80_0000, 5'h0);
    tick();
    chk("s1_bp_occ1", a_occ, 1);
    drive_a(1'b1, 32'h4000_0000, 5'h0);
    tick();
    chk("s1_bp_occ2",  a_occ, 2);
    chk("s1_bp_rdy0",  a_in_ready, 0);
    chk("s1_bp_headA", a_out_word, 32'h3F80_0000);
    drive_a(1'b0, 32'h0, 5'h0);
    tick();
    chk("s1_bp_stableA", a_out_word, 32'h3F80_0000);
    chk("s1_bp_stable_occ", a_occ, 2);
    a_out_ready = 1'b1;
    #1;
    chk("s1_rel_A", a_out_word, 32'h3F80_0000);
    tick();
    chk("s1_rel_B",    a_out_word, 32'h4000_0000);
    chk("s1_rel_occ1", a_occ, 1);
    chk("s1_rel_rdy",  a_in_ready, 1);
    tick();
    chk("s1_rel_occ0", a_occ, 0);
    chk("s1_rel_v0",   a_out_valid, 0);

    // SKID=1 flush while FULL with input offered
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h3F80_0000, 5'h0); tick();
    drive_a(1'b1, 32'h4000_0000, 5'h0); tick();
    chk("s1_fl_occ2", a_occ, 2);
    a_flush = 1'b1;
    drive_a(1'b1, 32'h1111_1111, 5'h0);
    tick();
    chk("s1_fl_valid", a_out_valid, 0);
    chk("s1_fl_occ",   a_occ, 0);
    chk("s1_fl_rdy",   a_in_ready, 1);
    a_flush = 1'b0;
    drive_a(1'b0, 32'h0, 5'h0);
    a_out_ready = 1'b1;
    tick();
    chk("s1_fl_nothing", a_out_valid, 0);

    // SKID=1 flush while ONE with a real in_fire in the same cycle
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h2222_2222, 5'h0); tick();
    chk("s1_fl1_occ1", a_occ, 1);
    a_flush = 1'b1;
    drive_a(1'b1, 32'h3333_3333, 5'h0);
    tick();
    chk("s1_fl1_valid", a_out_valid, 0);
    chk("s1_fl1_occ",   a_occ, 0);
    a_flush = 1'b0;
    drive_a(1'b0, 32'h0, 5'h0);
    tick();
    chk("s1_fl1_dropped", a_out_valid, 0);
    a_out_ready = 1'b1;
    drive_a(1'b1, 32'h4444_4444, 5'h0);
    tick();
    chk("s1_after_fl_word", a_out_word, 32'h4444_4444);
    chk("s1_after_fl_occ",  a_occ, 1);

    // flags / NaN pass-through, both modes
    drive_a(1'b1, 32'h7FC0_0000, 5'b10101);
    b_out_ready = 1'b1;
    drive_b(1'b1, 32'h7FC0_0000, 5'b10101);
    tick();
    chk("s1_nan_sign",  a_out_sign, 0);
    chk("s1_nan_exp",   a_out_exp, 8'hFF);
    chk("s1_nan_sig",   a_out_sig, 23'h40_0000);
    chk("s1_nan_flags", a_out_flags, 5'b10101);
    chk("s0_nan_word",  b_out_word, 32'h7FC0_0000);
    chk("s0_nan_flags", b_out_flags, 5'b10101);
    drive_a(1'b0, 32'h0, 5'h0);
    drive_b(1'b0, 32'h0, 5'h0);
    tick();
    chk("s0_empty", b_out_valid, 0);

    // SKID=0 stall and pass-through with simultaneous in/out fire
    b_out_ready = 1'b0;
    drive_b(1'b1, 32'h7777_7777, 5'h1); tick();
    chk("s0_st_valid", b_out_valid, 1);
    chk("s0_st_occ",   b_occ, 1);
    drive_b(1'b1, 32'h8888_8888, 5'h2);
    #1;
    chk("s0_st_rdy0", b_in_ready, 0);
    tick();
    chk("s0_st_hold", b_out_word, 32'h7777_7777);
    b_out_ready = 1'b1;
    #1;
    chk("s0_st_rdy1", b_in_ready, 1);
    tick();
    chk("s0_st_next", b_out_word, 32'h8888_8888);
    chk("s0_st_flag", b_out_flags, 5'h2);

    // SKID=0 flush with simultaneous in_fire
    b_flush = 1'b1;
    drive_b(1'b1, 32'h6666_6666, 5'h0);
    tick();
    chk("s0_fl_valid", b_out_valid, 0);
    chk("s0_fl_occ",   b_occ, 0);
    b_flush = 1'b0;
    drive_b(1'b0, 32'h0, 5'h0);
    tick();
    chk("s0_fl_dropped", b_out_valid, 0);

    // SKID=0 random items with out_ready toggling 1,0,1,0
    mv = 1'b0; sent = 0; got = 0;
    cur = $urandom;
    for (int cyc = 0; cyc < 200 && (sent < 16 || exp_q.size() > 0); cyc++) begin
      b_out_ready = (cyc % 2 == 0);
      drive_b(sent < 16, cur, cur[4:0] ^ cur[31:27]);
      #1;
      exp_rdy = !mv | b_out_ready;
      chk("s0_rnd_rdy",   b_in_ready, exp_rdy);
      chk("s0_rnd_valid", b_out_valid, mv);
      out_f = mv & b_out_ready;
      in_f  = b_in_valid & exp_rdy;
      if (out_f) begin
        chk("s0_rnd_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          front = exp_q.pop_front();
          chk("s0_rnd_data", {b_out_flags, b_out_word}, front);
          got++;
        end
      end
      if (in_f) begin
        exp_q.push_back({cur[4:0] ^ cur[31:27], cur});
        sent++;
        cur = $urandom;
      end
      if (in_f) mv = 1'b1;
      else if (out_f) mv = 1'b0;
      tick();
    end
    chk("s0_rnd_sent", sent, 16);
    chk("s0_rnd_got",  got, 16);
    drive_b(1'b0, 32'h0, 5'h0);

    // asynchronous reset mid-stream in both modes
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    drive_a(1'b1, 32'hAAAA_AAAA, 5'h3); tick();
    drive_a(1'b1, 32'hBBBB_BBBB, 5'h4);
    drive_b(1'b1, 32'hCCCC_CCCC, 5'h5); tick();
    chk("mid_a_occ2", a_occ, 2);
    chk("mid_b_occ1", b_occ, 1);
    drive_a(1'b0, 32'h0, 5'h0);
    drive_b(1'b0, 32'h0, 5'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_a_valid", a_out_valid, 0);
    chk("arst_a_occ",   a_occ, 0);
    chk("arst_a_word",  {a_out_flags, a_out_word}, 0);
    chk("arst_b_valid", b_out_valid, 0);
    chk("arst_b_occ",   b_occ, 0);
    chk("arst_b_word",  {b_out_flags, b_out_word}, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst_rel_a_rdy", a_in_ready, 1);
    chk("arst_rel_a_occ", a_occ, 0);
    // skid entry was discarded: one new item, then nothing else follows it
    a_out_ready = 1'b1;
    drive_a(1'b1, 32'hDDDD_DDDD, 5'h0); tick();
    chk("arst_new_item", a_out_word, 32'hDDDD_DDDD);
    drive_a(1'b0, 32'h0, 5'h0); tick();
    chk("arst_no_stale", a_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
